instr_fetch_buffer: RTL
=======================

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of 16-bit instruction entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port byte_in, input, 8 bits: instruction byte stream, low byte first.
REQ-005 SHALL have port byte_valid, input, 1 bit: byte_in holds a valid byte.
REQ-006 SHALL have port byte_ready, output, 1 bit: block accepts byte_in this cycle.
REQ-007 SHALL have port flush, input, 1 bit: discard all buffered and partial instructions.
REQ-008 SHALL have port instr_out, output, 16 bits: head instruction, {high byte, low byte}, feeding the core's {uio_in, ui_in}.
REQ-009 SHALL have port instr_valid, output, 1 bit: instr_out is valid.
REQ-010 SHALL have port instr_ready, input, 1 bit: core consumes instr_out this cycle.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of full instructions stored.

Function
REQ-012 SHALL accept a byte when byte_valid and byte_ready are both high at a rising edge.
REQ-013 SHALL implement assembler FSM states LOW (expecting low byte) and HIGH (low byte held in lo_reg).
REQ-014 In LOW, an accepted byte SHALL load lo_reg and move the FSM to HIGH.
REQ-015 In HIGH, an accepted byte SHALL push {byte_in, lo_reg} into the FIFO and move the FSM to LOW.
REQ-016 byte_ready SHALL be 1 in LOW, and !full in HIGH, where full means count==DEPTH; byte_ready SHALL NOT depend combinationally on instr_ready.
REQ-017 An instruction SHALL pop when instr_valid and instr_ready are both high at a rising edge.
REQ-018 instr_valid SHALL equal (count!=0), registered-state derived; instr_out SHALL equal the head entry when valid and 16'h0000 when empty.
REQ-019 The head SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-020 Latency SHALL be one cycle: a high byte accepted at edge N makes instr_valid=1 after edge N when the FIFO was empty; there is no same-cycle bypass.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-023 instr_ready with the FIFO empty SHALL be ignored.
REQ-024 flush SHALL take priority over push and pop in the same cycle: count becomes 0, the FSM returns to LOW, and lo_reg is discarded.

Reset
REQ-025 On rst=1 at a rising edge: FSM=LOW, pointers=0, count=0, lo_reg=8'h00.
REQ-026 Outputs during and after reset SHALL be instr_valid=0, instr_out=16'h0000, and byte_ready=1.
REQ-027 Reset SHALL take priority over flush, push and pop.
REQ-028 Reset asserted mid-instruction (in HIGH) SHALL drop the partial byte.

Structure
REQ-029 Shared package riscv_mini_pkg SHALL hold INSTR_W=16, BYTE_W=8, and the assembler state enum {LOW, HIGH}.
REQ-030 Storage SHALL be one sub-module sync_fifo (parameters WIDTH and DEPTH; push, pop, flush, full, empty, count).
REQ-031 The assembler FSM and lo_reg SHALL live in instr_fetch_buffer.

Verification
REQ-032 Basic: bytes 8'h25, 8'h01 with instr_ready=0 -> instr_valid=1 with instr_out=16'h0125 on the next cycle, count=1.
REQ-033 Full: 4 instructions pushed, then byte 8'hAA (LOW->HIGH) accepted -> byte_ready=0; the following byte is stalled until one pop, then accepted.
REQ-034 Simultaneous: count=2, high byte accepted while popping -> count stays 2 and pop order matches push order.
REQ-035 Flush: 3 entries stored plus a partial low byte, flush=1 with byte_valid=1 -> count=0, instr_valid=0, FSM=LOW, and the byte is not stored.
REQ-036 Reset mid-op: rst=1 in HIGH -> the next byte pair 8'h34, 8'h12 yields 16'h1234, not a misaligned word.
REQ-037 Wrap: 10 instructions streamed with instr_ready toggling -> all 10 are output in order with no loss across pointer wraparound.

Source files
------------

// File: rtl/riscv_mini_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mini_pkg
// Brief    : Shared widths and the instruction-assembler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_mini_pkg;

    localparam int INSTR_W = 16;
    localparam int BYTE_W  = 8;

    typedef enum logic [0:0] {
        LOW  = 1'b0,
        HIGH = 1'b1
    } asm_state_t;

endpackage : riscv_mini_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with registered occupancy count and flush.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_buffer
// Brief    : Assembles a low-byte-first byte stream into 16-bit instructions.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_buffer
    import riscv_mini_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BYTE_W-1:0]        byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    input  logic                     flush,
    output logic [INSTR_W-1:0]       instr_out,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   count
);

    asm_state_t          r_state;
    asm_state_t          w_state_next;
    logic [BYTE_W-1:0]   lo_reg;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOW;
        end else begin
            r_state <= w_state_next;
        end
    end

    // byte_ready looks only at registered state so it never waits on the core.
    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b1;
        if (r_state == HIGH) begin
            byte_ready = !w_full;
        end
        w_accept = byte_valid && byte_ready;
        w_push   = w_accept && (r_state == HIGH);
        w_pop    = instr_ready && !w_empty;
        if (flush) begin
            w_state_next = LOW;
        end else if (w_accept) begin
            w_state_next = (r_state == LOW) ? HIGH : LOW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            lo_reg <= '0;
        end else if (w_accept && (r_state == LOW)) begin
            lo_reg <= byte_in;
        end
    end

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (flush),
        .wdata ({byte_in, lo_reg}),
        .rdata (instr_out),
        .full  (w_full),
        .empty (w_empty),
        .count (count)
    );

    assign instr_valid = !w_empty;

endmodule : instr_fetch_buffer
`default_nettype wire
